// File: rtl/keypad_codes_pkg.sv
// keypad_codes: key-code constants and scanner state encoding, shared by the
// keypad scanner and the calculator FSM. It also holds two small helpers for
// active-low row/column vectors.
package keypad_codes;

  localparam logic [7:0] encout_0     = 8'h00;
  localparam logic [7:0] encout_1     = 8'h01;
  localparam logic [7:0] encout_2     = 8'h02;
  localparam logic [7:0] encout_3     = 8'h03;
  localparam logic [7:0] encout_4     = 8'h04;
  localparam logic [7:0] encout_5     = 8'h05;
  localparam logic [7:0] encout_6     = 8'h06;
  localparam logic [7:0] encout_7     = 8'h07;
  localparam logic [7:0] encout_8     = 8'h08;
  localparam logic [7:0] encout_9     = 8'h09;
  localparam logic [7:0] encout_Add   = 8'hF0;
  localparam logic [7:0] encout_Sub   = 8'hF1;
  localparam logic [7:0] encout_Mul   = 8'hF2;
  localparam logic [7:0] encout_Div   = 8'hF3;
  localparam logic [7:0] encout_Clear = 8'h80;
  localparam logic [7:0] encout_Equ   = 8'h81;
  localparam logic [7:0] encout_Idle  = 8'hFF;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } kp_state_e;

  // True when exactly one bit of an active-low vector is low.
  function automatic logic one_low(input logic [3:0] v);
    return ($countones(~v) == 1);
  endfunction

  // Index of the low bit of an active-low one-hot vector.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the decoded key outputs.
//   row       keypad rows, active-low
//   col       column strobes, active-low one-hot
//   code      key code, 8'hFF when idle
//   pressed   debounced key-held level
//   key_valid one-cycle pulse on press acceptance
// master = scanner side, slave = keypad / consumer side.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [7:0] code;
  logic       pressed;
  logic       key_valid;

  modport master (input row, output col, output code, output pressed, output key_valid);
  modport slave  (output row, input col, input code, input pressed, input key_valid);
endinterface

// File: rtl/keypad_keymap.sv
// keypad_keymap: combinational (row index, column index) -> 8-bit key code.
//   r_idx  row index 0..3
//   c_idx  column index 0..3
//   code   key code from keypad_codes
module keypad_keymap
  import keypad_codes::*;
(
  input  logic [1:0] r_idx,
  input  logic [1:0] c_idx,
  output logic [7:0] code
);
  always_comb begin
    code = encout_Idle;
    case ({r_idx, c_idx})
      4'h0: code = encout_1;
      4'h1: code = encout_2;
      4'h2: code = encout_3;
      4'h3: code = encout_Add;
      4'h4: code = encout_4;
      4'h5: code = encout_5;
      4'h6: code = encout_6;
      4'h7: code = encout_Sub;
      4'h8: code = encout_7;
      4'h9: code = encout_8;
      4'hA: code = encout_9;
      4'hB: code = encout_Mul;
      4'hC: code = encout_Clear;
      4'hD: code = encout_0;
      4'hE: code = encout_Equ;
      4'hF: code = encout_Div;
      default: code = encout_Idle;
    endcase
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce.
//   clk  system clock
//   rst  synchronous active-high reset
//   kp   keypad_scanner_if.master: row in; col, code, pressed, key_valid out
// Every output comes straight from a flop, so no combinational path runs from
// row to the outputs.
module keypad_scanner
  import keypad_codes::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input logic              clk,
  input logic              rst,
  keypad_scanner_if.master kp
);
  localparam int MAX_CNT = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW      = $clog2(MAX_CNT) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    ROW_IDLE = 4'hF;
  localparam logic [3:0]    COL_RST  = 4'b1110;

  kp_state_e     state_q, state_d;
  logic [3:0]    col_q, col_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]    cand_row_q, cand_row_d;
  logic [1:0]    cand_r_q, cand_r_d;
  logic [7:0]    code_q, code_d;
  logic          pressed_q, pressed_d;
  logic          key_valid_q, key_valid_d;
  logic [7:0]    map_code;

  // col stays frozen from candidate latch until release, so its index is the
  // candidate column.
  keypad_keymap u_keymap (
    .r_idx (cand_r_q),
    .c_idx (low_idx(col_q)),
    .code  (map_code)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    div_cnt_d   = div_cnt_q;
    db_cnt_d    = db_cnt_q;
    cand_row_d  = cand_row_q;
    cand_r_d    = cand_r_q;
    code_d      = code_q;
    pressed_d   = pressed_q;
    key_valid_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (one_low(kp.row)) begin
            cand_row_d = kp.row;
            cand_r_d   = low_idx(kp.row);
            db_cnt_d   = '0;
            state_d    = PRESS_DB;
          end else begin
            col_d = {col_q[2:0], col_q[3]};
          end
        end else begin
          div_cnt_d = div_cnt_q + CNT_ONE;
        end
      end
      PRESS_DB: begin
        if (kp.row == cand_row_q) begin
          if (db_cnt_q == DB_LAST) begin
            state_d     = HELD;
            code_d      = map_code;
            pressed_d   = 1'b1;
            key_valid_d = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + CNT_ONE;
          end
        end else begin
          // Bounce during the press: abandon this candidate and move on.
          state_d   = SCAN;
          col_d     = {col_q[2:0], col_q[3]};
          div_cnt_d = '0;
        end
      end
      HELD: begin
        // Only a full release matters; extra keys on this column are ignored.
        if (kp.row == ROW_IDLE) begin
          db_cnt_d = '0;
          state_d  = REL_DB;
        end
      end
      REL_DB: begin
        if (kp.row == ROW_IDLE) begin
          if (db_cnt_q == DB_LAST) begin
            state_d   = SCAN;
            pressed_d = 1'b0;
            code_d    = encout_Idle;
            col_d     = {col_q[2:0], col_q[3]};
            div_cnt_d = '0;
          end else begin
            db_cnt_d = db_cnt_q + CNT_ONE;
          end
        end else begin
          db_cnt_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      col_q       <= COL_RST;
      div_cnt_q   <= '0;
      db_cnt_q    <= '0;
      cand_row_q  <= ROW_IDLE;
      cand_r_q    <= 2'd0;
      code_q      <= encout_Idle;
      pressed_q   <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      div_cnt_q   <= div_cnt_d;
      db_cnt_q    <= db_cnt_d;
      cand_row_q  <= cand_row_d;
      cand_r_q    <= cand_r_d;
      code_q      <= code_d;
      pressed_q   <= pressed_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign kp.col       = col_q;
  assign kp.code      = code_q;
  assign kp.pressed   = pressed_q;
  assign kp.key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model plus a key-code scoreboard. Expected
// codes are queued when a key is driven and popped on each key_valid pulse.
module tb_keypad_scanner;
  localparam int SD  = 4;
  localparam int DEB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  // Keypad model: the held key pulls its row pattern low only while its
  // column strobe is low.
  logic       key_on   = 1'b0;
  logic       row_zero = 1'b1;
  logic [3:0] kp_pat   = 4'hF;
  logic [1:0] kp_c     = 2'd0;
  logic [3:0] row_m;
  always_comb begin
    row_m = 4'hF;
    if (row_zero) row_m = 4'h0;
    else if (key_on && (kif.col[kp_c] == 1'b0)) row_m = kp_pat;
  end
  assign kif.row = row_m;

  int total = 0;
  int bad   = 0;
  int kv_cnt = 0;
  int falls  = 0;
  logic prev_pressed = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every key_valid pulse must match the oldest queued code.
  always @(negedge clk) begin
    if (!rst && kif.key_valid) begin
      kv_cnt++;
      chk("kv_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("kv_code", 32'(kif.code), 32'(exp_q.pop_front()));
    end
    if (prev_pressed && !kif.pressed) falls++;
    prev_pressed = kif.pressed;
  end

  task automatic set_key(input int r, input int c);
    kp_pat = 4'(~(4'b0001 << r));
    kp_c   = 2'(c);
    key_on = 1'b1;
  endtask

  // Edges until pressed reaches lvl (sampled 1 time unit after each edge); -1 on timeout.
  task automatic wait_pressed(input logic lvl, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk); #1;
      if (kif.pressed === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_col(input logic [3:0] v, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk); #1;
      if (kif.col === v) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int kv0;
    int f0;
    logic stay_hi;
    logic saw_adv;
    logic [3:0] ce;

    // Reset with all rows low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_col", 32'(kif.col), 32'h0E);
    chk("rst_code", 32'(kif.code), 32'hFF);
    chk("rst_pressed", 32'(kif.pressed), 32'd0);
    chk("rst_kv", 32'(kif.key_valid), 32'd0);
    rst = 1'b0;
    row_zero = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ce = ~(4'b0001 << ((k / SD) % 4));
      chk("scan_col", 32'(kif.col), 32'(ce));
      @(posedge clk); #1;
    end

    // Clean press of '5' (row1, col1): latch at end of col1 dwell, pressed DEB later.
    set_key(1, 1);
    exp_q.push_back(8'h05);
    wait_col(4'b1101, 20, n);
    chk("col1_reached", 32'(n), 32'(SD));
    wait_pressed(1'b1, 40, n);
    chk("press_latency", 32'(n), 32'(SD + DEB));
    chk("press_code", 32'(kif.code), 32'h05);
    chk("press_kv", 32'(kif.key_valid), 32'd1);
    @(posedge clk); #1;
    chk("kv_one_cycle", 32'(kif.key_valid), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("held_col", 32'(kif.col), 32'h0D);
    chk("held_pressed", 32'(kif.pressed), 32'd1);
    chk("held_code", 32'(kif.code), 32'h05);
    key_on = 1'b0;
    // One edge for HELD to see the release, then DEB counted idle cycles.
    wait_pressed(1'b0, 40, n);
    chk("release_latency", 32'(n), 32'(1 + DEB));
    chk("release_code", 32'(kif.code), 32'hFF);

    // Press bounce on '=' (row3, col2): low 3 / high 1, then steady.
    kv0 = kv_cnt;
    kp_pat = 4'b0111;
    kp_c = 2'd2;
    for (int b = 0; b < 8; b++) begin
      key_on = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      key_on = 1'b0;
      @(posedge clk); #1;
    end
    chk("bounce_no_kv", 32'(kv_cnt), 32'(kv0));
    exp_q.push_back(8'h81);
    key_on = 1'b1;
    wait_pressed(1'b1, 80, n);
    chk("bounce_pressed", 32'(n > 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bounce_one_kv", 32'(kv_cnt), 32'(kv0 + 1));
    key_on = 1'b0;
    wait_pressed(1'b0, 40, n);
    chk("bounce_release", 32'(n), 32'(1 + DEB));

    // Release bounce on '+' (row0, col3): high 5 / low 1, then steady high.
    set_key(0, 3);
    exp_q.push_back(8'hF0);
    wait_pressed(1'b1, 80, n);
    chk("plus_pressed", 32'(n > 0), 32'd1);
    f0 = falls;
    stay_hi = 1'b1;
    for (int b = 0; b < 3; b++) begin
      key_on = 1'b0;
      repeat (5) begin
        @(posedge clk); #1;
        if (!kif.pressed) stay_hi = 1'b0;
      end
      key_on = 1'b1;
      @(posedge clk); #1;
      if (!kif.pressed) stay_hi = 1'b0;
    end
    key_on = 1'b0;
    // Already debouncing the release: DEB all-high samples from here.
    wait_pressed(1'b0, 40, n);
    chk("relbounce_stay_hi", 32'(stay_hi), 32'd1);
    chk("relbounce_latency", 32'(n), 32'(DEB));
    repeat (2) @(posedge clk);
    #1;
    chk("relbounce_one_fall", 32'(falls), 32'(f0 + 1));

    // Multi-key on col0 (rows 0 and 1): ignored until it resolves to '1'.
    kv0 = kv_cnt;
    kp_c = 2'd0;
    kp_pat = 4'b1100;
    key_on = 1'b1;
    saw_adv = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (kif.col !== 4'b1110) saw_adv = 1'b1;
    end
    chk("multi_advance", 32'(saw_adv), 32'd1);
    chk("multi_no_kv", 32'(kv_cnt), 32'(kv0));
    chk("multi_no_press", 32'(kif.pressed), 32'd0);
    exp_q.push_back(8'h01);
    kp_pat = 4'b1110;
    wait_pressed(1'b1, 80, n);
    chk("multi_resolved", 32'(n > 0), 32'd1);
    key_on = 1'b0;
    wait_pressed(1'b0, 40, n);
    chk("multi_release", 32'(n), 32'(1 + DEB));

    // Reset while '*' (row2, col3) is held, then re-detection.
    set_key(2, 3);
    exp_q.push_back(8'hF2);
    wait_pressed(1'b1, 80, n);
    chk("mul_pressed", 32'(n > 0), 32'd1);
    exp_q.push_back(8'hF2);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_pressed", 32'(kif.pressed), 32'd0);
    chk("midrst_code", 32'(kif.code), 32'hFF);
    chk("midrst_col", 32'(kif.col), 32'h0E);
    rst = 1'b0;
    wait_pressed(1'b1, 60, n);
    chk("midrst_redetect", 32'(n > 0 && n <= SD * 4 + DEB), 32'd1);
    key_on = 1'b0;
    wait_pressed(1'b0, 40, n);
    chk("midrst_release", 32'(n), 32'(1 + DEB));

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
